// File: rtl/pattern_scan_ctrl.sv
// Programmable serial pattern-scan controller: run-time configurable detector
// (pattern, length, overlap, match limit) sequenced through IDLE / RUN / DONE.
module pattern_scan_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_limit,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              match,
  output logic [CNTW-1:0]   match_cnt,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Configuration registers
  logic [MAXLEN-1:0] pattern_q;
  logic [3:0]        len_q;
  logic              overlap_q;
  logic [CNTW-1:0]   limit_q;

  // Engine state: shift history and number of valid history bits
  logic [MAXLEN-1:0] hist_q;
  logic [3:0]        fill_q;

  logic              cfg_legal;
  logic              cfg_load;
  logic              cfg_bad;
  logic              start_ok;
  logic              accept;
  logic [MAXLEN-1:0] hist_shift;
  logic [3:0]        fill_inc;
  logic [MAXLEN-1:0] cmp_mask;
  logic              hit;
  logic [CNTW-1:0]   cnt_inc;
  logic              limit_hit;

  // Low len bits set; selects the compared window of history and pattern.
  function automatic logic [MAXLEN-1:0] len_mask(input logic [3:0] len);
    logic [MAXLEN-1:0] m;
    for (int i = 0; i < MAXLEN; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  // Control decode
  assign cfg_legal = (cfg_len != 4'd0) && (cfg_len <= 4'(MAXLEN));
  assign cfg_load  = cfg_we && (state_q != ST_RUN) && cfg_legal;
  assign cfg_bad   = cfg_we && ((state_q == ST_RUN) || !cfg_legal);
  assign start_ok  = start && !cfg_we && !cfg_err && (state_q != ST_RUN);
  assign accept    = in_valid && in_ready;

  // Detection datapath
  assign hist_shift = {hist_q[MAXLEN-2:0], in_bit};
  assign fill_inc   = (fill_q == 4'(MAXLEN)) ? fill_q : fill_q + 4'd1;
  assign cmp_mask   = len_mask(len_q);
  assign hit        = accept && (fill_inc >= len_q) &&
                      ((hist_shift & cmp_mask) == (pattern_q & cmp_mask));
  assign cnt_inc    = (match_cnt == '1) ? match_cnt : match_cnt + CNTW'(1);
  assign limit_hit  = hit && (limit_q != '0) && (cnt_inc == limit_q);

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN: begin
        if (abort)          state_d = ST_IDLE;
        else if (limit_hit) state_d = ST_DONE;
      end
      ST_DONE: if (start_ok) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: in_ready depends on state and abort only, never in_valid.
  always_comb begin
    in_ready = (state_q == ST_RUN) && !abort;
  end

  // Configuration registers and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pattern_q <= MAXLEN'(4'b1010);
      len_q     <= 4'd4;
      overlap_q <= 1'b0;
      limit_q   <= '0;
      cfg_err   <= 1'b0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
      overlap_q <= cfg_overlap;
      limit_q   <= cfg_limit;
      cfg_err   <= 1'b0;
    end else if (cfg_bad) begin
      cfg_err   <= 1'b1;
    end
  end

  // Detection engine; start and accept are exclusive (accept needs RUN).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= 4'd0;
      match_cnt <= '0;
      done      <= 1'b0;
    end else if (start_ok) begin
      hist_q    <= '0;
      fill_q    <= 4'd0;
      match_cnt <= '0;
      done      <= 1'b0;
    end else if (accept) begin
      hist_q <= hist_shift;
      // Non-overlap mode discards history so matched bits are not reused.
      fill_q <= (hit && !overlap_q) ? 4'd0 : fill_inc;
      if (hit)       match_cnt <= cnt_inc;
      if (limit_hit) done      <= 1'b1;
    end
  end

  // Registered status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match <= 1'b0;
      busy  <= 1'b0;
    end else begin
      match <= hit;
      busy  <= (state_d == ST_RUN);
    end
  end

  a_busy_tracks_run : assert property (
    @(posedge clk) disable iff (!rst_n) busy == (state_q == ST_RUN));
  a_done_tracks_done : assert property (
    @(posedge clk) disable iff (!rst_n) done == (state_q == ST_DONE));

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: hand-computed match / count / status
// expectations for default, overlap, limit, config-error, abort and reset cases.
module tb_pattern_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_limit;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       match;
  logic [7:0] match_cnt;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int vectors;
  int miscompares;

  pattern_scan_ctrl #(.MAXLEN(8), .CNTW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_limit  (cfg_limit),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .match      (match),
    .match_cnt  (match_cnt),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                           input logic [7:0] lim, input logic with_start);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_limit   = lim;
    start       = with_start;
    tick();
    cfg_we = 1'b0;
    start  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic b, input logic exp_match, input string tag);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
    check(tag, match, exp_match);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cfg_limit = '0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_ready", in_ready, 0);
    check("rst_match", match, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", cfg_err, 0);

    // Default 1010/4, non-overlap
    pulse_start();
    check("t1_busy", busy, 1);
    check("t1_ready", in_ready, 1);
    send(1, 0, "t1_b1");
    send(0, 0, "t1_b2");
    send(1, 0, "t1_b3");
    send(0, 1, "t1_b4");
    check("t1_cnt4", match_cnt, 1);
    send(1, 0, "t1_b5");
    send(0, 0, "t1_b6");
    check("t1_cnt6", match_cnt, 1);

    // Abort with in_valid high
    in_valid = 1'b1; in_bit = 1'b1; abort = 1'b1;
    #1;
    check("ab_ready", in_ready, 0);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_cnt", match_cnt, 1);
    check("ab_match", match, 0);
    pulse_start();
    check("ab_restart_cnt", match_cnt, 0);
    check("ab_restart_busy", busy, 1);
    do_abort();

    // Overlap mode; illegal cfg_we during RUN leaves config untouched
    write_cfg(8'b1010, 4'd4, 1'b1, 8'd0, 1'b0);
    check("t2_err", cfg_err, 0);
    pulse_start();
    send(1, 0, "t2_b1");
    send(0, 0, "t2_b2");
    send(1, 0, "t2_b3");
    send(0, 1, "t2_b4");
    write_cfg(8'hFF, 4'd4, 1'b0, 8'd0, 1'b0);
    check("t2_run_cfg_err", cfg_err, 1);
    check("t2_run_busy", busy, 1);
    send(1, 0, "t2_b5");
    send(0, 1, "t2_b6");
    check("t2_cnt", match_cnt, 2);
    do_abort();

    // Start ignored while cfg_err set
    pulse_start();
    check("err_start_busy", busy, 0);

    // len 1, limit 3: back-to-back hits then DONE
    write_cfg(8'h01, 4'd1, 1'b0, 8'd3, 1'b0);
    check("t3_err", cfg_err, 0);
    pulse_start();
    in_valid = 1'b1; in_bit = 1'b1;
    tick();
    check("t3_m1", match, 1);
    check("t3_c1", match_cnt, 1);
    tick();
    check("t3_m2", match, 1);
    check("t3_c2", match_cnt, 2);
    check("t3_done2", done, 0);
    tick();
    check("t3_m3", match, 1);
    check("t3_c3", match_cnt, 3);
    check("t3_done3", done, 1);
    check("t3_busy3", busy, 0);
    check("t3_ready3", in_ready, 0);
    tick();
    check("t3_m4", match, 0);
    check("t3_c4", match_cnt, 3);
    check("t3_done4", done, 1);
    in_valid = 1'b0;

    // Illegal lengths in DONE, then cfg_we+start in the same cycle
    write_cfg(8'h55, 4'd0, 1'b0, 8'd0, 1'b0);
    check("t4_len0_err", cfg_err, 1);
    pulse_start();
    check("t4_start_busy", busy, 0);
    check("t4_start_done", done, 1);
    check("t4_start_cnt", match_cnt, 3);
    write_cfg(8'hAA, 4'd9, 1'b0, 8'd0, 1'b0);
    check("t4_len9_err", cfg_err, 1);
    write_cfg(8'b110, 4'd3, 1'b0, 8'd0, 1'b1);
    check("t4_legal_err", cfg_err, 0);
    check("t4_cfgwins_busy", busy, 0);
    check("t4_cfgwins_done", done, 1);
    pulse_start();
    check("t4_busy", busy, 1);
    check("t4_done", done, 0);
    check("t4_cnt", match_cnt, 0);
    send(1, 0, "t4_b1");
    send(1, 0, "t4_b2");
    send(0, 1, "t4_b3");
    write_cfg(8'h00, 4'd4, 1'b0, 8'd0, 1'b0);
    check("t4_run_err", cfg_err, 1);
    send(1, 0, "t5_b1");
    send(0, 0, "t5_b2");
    send(1, 0, "t5_b3");

    // Mid-stream reset restores outputs and the default config
    rst_n = 1'b0; in_valid = 1'b1; in_bit = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    check("t5_ready", in_ready, 0);
    check("t5_match", match, 0);
    check("t5_cnt", match_cnt, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_err", cfg_err, 0);
    pulse_start();
    send(0, 0, "t5_r1");
    send(1, 0, "t5_r2");
    send(0, 0, "t5_r3");
    send(1, 0, "t5_r4");
    send(0, 1, "t5_r5");
    check("t5_cnt_end", match_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Programmable serial pattern-scan controller. It owns a configurable pattern detector of up to MAXLEN bits, loads its configuration, and sequences scan sessions (start / run / abort / done). It accepts serial bits through a valid/ready handshake and reports matches, a match count and completion to the surrounding control logic. It replaces fixed-pattern hard-coded detectors wherever the pattern, overlap mode or stop condition must be set at run time.

## Interface
- MAXLEN, 8, maximum pattern length in bits (2..15)
- CNTW, 8, width of match counter and limit
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  configuration write strobe
- cfg_pattern  in  MAXLEN  pattern; bit [cfg_len-1] is the first bit received, bit 0 the last
- cfg_len  in  4  pattern length, legal 1..MAXLEN
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_limit  in  CNTW  matches before DONE; 0 = unlimited
- start  in  1  begin scan session
- abort  in  1  terminate scan session
- in_valid  in  1  serial bit valid
- in_bit  in  1  serial data bit
- in_ready  out  1  controller can accept a bit
- match  out  1  one-cycle pulse per detected match
- match_cnt  out  CNTW  matches in current session
- busy  out  1  session running
- done  out  1  match limit reached
- cfg_err  out  1  sticky configuration error

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Config registers reset to pattern 'b1010 (zero-extended), len 4, overlap 0, limit 0.
- cfg_we in IDLE or DONE with a legal cfg_len: all four config registers load and cfg_err clears. cfg_we with cfg_len = 0 or > MAXLEN: config is unchanged and cfg_err is set. cfg_we in RUN: config is unchanged and cfg_err is set.
- start in IDLE or DONE with cfg_err = 0: hist is cleared, fill = 0, match_cnt = 0, done = 0, and the state moves to RUN. start is ignored when cfg_err = 1, when the controller is in RUN, or when cfg_we is asserted in the same cycle (cfg_we wins).
- Engine state: hist (MAXLEN bits), fill (0..MAXLEN, count of valid history bits).
- Accept = in_valid & in_ready. On accept:
  - hist' = {hist[MAXLEN-2:0], in_bit}
  - fill' = min(fill+1, MAXLEN)
  - hit = (fill' ≥ len) and hist'[len-1:0] == pattern[len-1:0]
- On hit:
  - match_cnt increments, saturating at all-ones.
  - If cfg_overlap = 0, fill is set to 0 (history discarded, so no reuse of matched bits).
  - If limit ≠ 0 and the new count == limit: state → DONE.
- abort in RUN: state → IDLE; match_cnt holds; no bit is accepted that cycle. abort in IDLE or DONE is ignored.
- DONE holds match_cnt and done until start, or until cfg_we followed by start.
- With limit = 0, the session runs until abort. A saturated counter does not stop the session.

## Timing
- Reset values: in_ready 0, match 0, match_cnt 0, busy 0, done 0, cfg_err 0; state IDLE; fill 0; hist 0.
- in_ready = (state == RUN) & ~abort. This is combinational from state and abort only, never from in_valid.
- match, match_cnt, done and the state change are registered on the same edge that accepts the hitting bit. They are visible the cycle after the accept, and match lasts exactly 1 cycle.
- Back-to-back accepts are supported at 1 bit/cycle, including consecutive hits (e.g. len 1).
- busy = (state == RUN), registered. It rises the cycle after start and falls the cycle after abort or the final hit.
- On the final hit the match pulse and done rise together, and in_ready drops in that same cycle.
- Bits with in_valid = 0 do not shift hist.
- rst_n low in any state aborts the session on that edge and restores all reset values, including the config registers.

## Test plan
- Default config, start, bits 1,0,1,0,1,0 → one match pulse after the 4th accept; match_cnt = 1; the 6th bit gives no match (non-overlap).
- cfg overlap = 1, pattern 1010, len 4 → the same stream gives matches after accepts 4 and 6; match_cnt = 2.
- cfg pattern 1, len 1, limit 3; stream 1,1,1,1 → matches on 3 consecutive cycles; done = 1 and in_ready = 0 after the 3rd; the 4th bit is not accepted; match_cnt = 3.
- cfg_len 0 → cfg_err = 1, config unchanged; a subsequent start is ignored (busy stays 0); a legal cfg_we clears cfg_err.
- In RUN with in_valid held high, abort for 1 cycle → in_ready = 0 that cycle; state is IDLE next cycle; match_cnt is retained; a later start clears match_cnt to 0.
- rst_n low for 1 cycle mid-stream after 1,0,1 → all outputs return to reset values; after restart the stream 0,1,0 produces no match.
